avg_unpool_layer: RTL

2x2 un-pooling stage for the CNN core: the inverse-direction counterpart of the 2x2 average-pooling layer. Takes a (FM_WIDTH/2)x(FM_HEIGHT/2) feature map and expands it to FM_WIDTH x FM_HEIGHT. Each input element is replicated into its 2x2 output window, and is optionally scaled by 1/4 to form the average-pool backward gradient. Output is emitted as a raster-order valid/ready stream and is also accumulated into a full output map register.

---
 rtl/avg_unpool_layer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/avg_unpool_layer.sv
// avg_unpool_layer: 2x2 un-pooling, raster valid/ready stream plus output map.
// Optional macro UNPOOL_SCALE_EN scales each element by 1/4 (>>> 2).
module avg_unpool_layer #(
  parameter int FM_WIDTH  = 6,
  parameter int FM_HEIGHT = 6,
  parameter int DATA_W    = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [DATA_W*(FM_WIDTH/2)*(FM_HEIGHT/2)-1:0] in_fm,
  output logic out_valid,
  input  logic out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [$clog2(FM_WIDTH*FM_HEIGHT)-1:0] out_idx,
  output logic busy,
  output logic done,
  output logic [DATA_W*FM_WIDTH*FM_HEIGHT-1:0] out_fm
);

  localparam int IW    = FM_WIDTH / 2;
  localparam int N_IN  = IW * (FM_HEIGHT / 2);
  localparam int N_OUT = FM_WIDTH * FM_HEIGHT;
  localparam int IDX_W = $clog2(N_OUT);
  localparam int SRC_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW    = $clog2(FM_WIDTH);
  localparam int RW    = $clog2(FM_HEIGHT);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             load;
  logic             accept;

  logic signed [DATA_W-1:0] src_buf [N_IN];
  logic        [DATA_W-1:0] fm_q    [N_OUT];

  logic [SRC_W-1:0]         src_k;
  logic signed [DATA_W-1:0] src_val;

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign out_idx   = idx_q;
  assign accept    = out_valid && out_ready;

  // Each 2x2 output window reads one source element
  assign src_k   = SRC_W'(int'(row_q >> 1) * IW + int'(col_q >> 1));
  assign src_val = src_buf[src_k];

`ifdef UNPOOL_SCALE_EN
  assign out_data = src_val >>> 2;
`else
  assign out_data = src_val;
`endif

  for (genvar j = 0; j < N_OUT; j++) begin : g_fm
    assign out_fm[j*DATA_W +: DATA_W] = fm_q[j];
  end

  // State and raster position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: launch, raster walk on accept, done pulse
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          idx_d = idx_q + IDX_W'(1);
          if (col_q == CW'(FM_WIDTH - 1)) begin
            col_d = '0;
            if (row_q == RW'(FM_HEIGHT - 1)) begin
              row_d   = '0;
              idx_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the input map when a run is launched
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) src_buf[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < N_IN; k++)
        src_buf[k] <= in_fm[k*DATA_W +: DATA_W];
    end
  end

  // Accumulate each accepted beat into the output map
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) fm_q[k] <= '0;
    end else if (accept) begin
      fm_q[idx_q] <= out_data;
    end
  end

endmodule
